// File: rtl/sd_pkg.sv
// Shared SD host definitions: frame geometry, CRC7 polynomial and the command TX state type.
// The serial CRC step lives here so the response receiver can reuse the same update rule.
package sd_pkg;

  localparam int         SD_CMD_FRAME_BITS = 48;
  localparam int         SD_CMD_HDR_BITS   = SD_CMD_FRAME_BITS - 8;
  localparam logic [6:0] SD_CRC7_POLY      = 7'h09;

  // state     | meaning
  // IDLE      | ready for a command, line released
  // WAIT_EDGE | fields captured, waiting for the first sd_clk fall
  // SHIFT     | driving start/transmission/index/argument bits
  // CRC       | driving crc7[6]..crc7[0]
  // END       | driving the end bit
  // GAP       | holding CMD high for the Ncc gap before release
  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    SHIFT,
    CRC,
    END,
    GAP
  } sd_cmd_tx_state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clk, synchronous clear.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] r_crc;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_crc <= '0;
    end else if (clear) begin
      r_crc <= '0;
    end else if (en) begin
      r_crc <= crc7_step(r_crc, din);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command frame transmitter: 48-bit frame with on-the-fly CRC7, driven on sd_clk falling edges,
// followed by an Ncc gap of CMD held high before the pad is released.
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int NCC_CYCLES = 8
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        sd_clk,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);

  localparam int GAP_W = (NCC_CYCLES < 2) ? 1 : $clog2(NCC_CYCLES + 1);

  sd_cmd_tx_state_t           r_state, w_state_nxt;
  logic [SD_CMD_HDR_BITS-1:0] r_shift, w_shift_nxt;
  logic [5:0]                 r_bit_cnt, w_bit_cnt_nxt;
  logic [GAP_W-1:0]           r_gap_cnt, w_gap_cnt_nxt;
  logic                       r_cmd_out, w_cmd_out_nxt;
  logic                       r_cmd_oe, w_cmd_oe_nxt;
  logic                       r_done, w_done_nxt;
  logic                       r_sd_clk_q;

  logic       w_fall;
  logic       w_ready;
  logic       w_crc_clear;
  logic       w_crc_en;
  logic       w_crc_din;
  logic [6:0] w_crc;

  assign w_fall  = r_sd_clk_q & ~sd_clk;
  // Held low during the done cycle so a new command is taken no earlier than done+1.
  assign w_ready = (r_state == IDLE) && !r_done;

  sd_crc7 u_crc7 (
    .clk   (clk),
    .res_n (res_n),
    .clear (w_crc_clear),
    .en    (w_crc_en),
    .din   (w_crc_din),
    .crc   (w_crc)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_cmd_out  <= 1'b1;
      r_cmd_oe   <= 1'b0;
      r_done     <= 1'b0;
      r_sd_clk_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_cmd_out  <= w_cmd_out_nxt;
      r_cmd_oe   <= w_cmd_oe_nxt;
      r_done     <= w_done_nxt;
      r_sd_clk_q <= sd_clk;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_cmd_out_nxt = r_cmd_out;
    w_cmd_oe_nxt  = r_cmd_oe;
    w_done_nxt    = 1'b0;
    w_crc_clear   = 1'b0;
    w_crc_en      = 1'b0;
    w_crc_din     = r_shift[SD_CMD_HDR_BITS-1];

    unique case (r_state)
      IDLE: begin
        if (cmd_valid && w_ready) begin
          w_shift_nxt = {2'b01, cmd_index, cmd_arg};
          w_crc_clear = 1'b1;
          w_state_nxt = WAIT_EDGE;
        end
      end

      WAIT_EDGE: begin
        if (w_fall) begin
          w_cmd_out_nxt = r_shift[SD_CMD_HDR_BITS-1];
          w_cmd_oe_nxt  = 1'b1;
          w_shift_nxt   = {r_shift[SD_CMD_HDR_BITS-2:0], 1'b0};
          w_crc_en      = 1'b1;
          w_bit_cnt_nxt = 6'd39;
          w_state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (w_fall) begin
          w_cmd_out_nxt = r_shift[SD_CMD_HDR_BITS-1];
          w_shift_nxt   = {r_shift[SD_CMD_HDR_BITS-2:0], 1'b0};
          w_crc_en      = 1'b1;
          // Count 1 means frame bit 8 is going out now; the CRC is complete on the next fall.
          if (r_bit_cnt == 6'd1) begin
            w_bit_cnt_nxt = 6'd6;
            w_state_nxt   = CRC;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 6'd1;
          end
        end
      end

      CRC: begin
        if (w_fall) begin
          w_cmd_out_nxt = w_crc[r_bit_cnt[2:0]];
          if (r_bit_cnt == 6'd0) begin
            w_state_nxt = END;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 6'd1;
          end
        end
      end

      END: begin
        if (w_fall) begin
          w_cmd_out_nxt = 1'b1;
          w_gap_cnt_nxt = GAP_W'(NCC_CYCLES);
          w_state_nxt   = GAP;
        end
      end

      GAP: begin
        w_cmd_out_nxt = 1'b1;
        if (w_fall) begin
          if (r_gap_cnt == '0) begin
            w_cmd_oe_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_state_nxt  = IDLE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cmd_ready = w_ready;
  assign cmd_out   = r_cmd_out;
  assign cmd_oe    = r_cmd_oe;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule
